// File: rtl/bpsk_demod_if.sv
// bpsk_demod_if: groups the BPSK waveform input and the recovered-frame outputs
// of the demodulator. The transmitter or bench side uses the master modport and
// the demodulator uses the slave modport.
// Optional feature macro: BPSK_DEMOD_ERR_EN adds the sym_err signal.
interface bpsk_demod_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wave_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  busy;
`ifdef BPSK_DEMOD_ERR_EN
    logic                  sym_err;

    modport master (output wave_in, input data_out, input data_valid, input busy, input sym_err);
    modport slave  (input wave_in, output data_out, output data_valid, output busy, output sym_err);
`else
    modport master (output wave_in, input data_out, input data_valid, input busy);
    modport slave  (input wave_in, output data_out, output data_valid, output busy);
`endif
endinterface

// File: rtl/bpsk_demod.sv
// bpsk_demod: BPSK demodulator locked to a transmitter that shares clk and leaves
// reset on the same edge. A free-running slot counter and slot index rebuild the
// reference carrier. One phase sample is taken in the middle of each half-period
// slot, and the samples of a bit period are counted for a majority decision.
// The first bit after reset is a preamble. Later bits are assembled LSB first
// into DATA_WIDTH-bit frames.
// Optional feature macro: BPSK_DEMOD_ERR_EN adds sym_err. It flags frames in
// which any bit had mixed samples.
module bpsk_demod #(
    parameter int CLOCK_IN      = 20_000_000,
    parameter int CLOCK_CARRIER = 64_000,
    parameter int DATA_WIDTH    = 8,
    parameter int CYCLE_COUNT   = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    bpsk_demod_if.slave  bus
);

    // Derived timing: clocks per half carrier period, and slots per bit
    localparam int H      = CLOCK_IN / (CLOCK_CARRIER * 2);
    localparam int S      = 2 * CYCLE_COUNT;
    localparam int SLOT_W = (H > 1) ? $clog2(H) : 1;
    localparam int IDX_W  = (S > 1) ? $clog2(S) : 1;
    localparam int ONES_W = $clog2(S + 1);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(H - 1);
    localparam logic [SLOT_W-1:0] SLOT_MID  = SLOT_W'(H / 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(S - 1);
    localparam logic [ONES_W-1:0] ONES_HALF = ONES_W'(CYCLE_COUNT);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        PREAMBLE = 1'b0,
        DATA     = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [SLOT_W-1:0]     slotCnt_q, slotCnt_d;
    logic [IDX_W-1:0]      slotIdx_q, slotIdx_d;
    logic [ONES_W-1:0]     ones_q, ones_d;
    logic                  tieBit_q, tieBit_d;
    logic [DATA_WIDTH-1:0] frame_q, frame_d;
    logic [BIT_W-1:0]      bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  dataValid_q, dataValid_d;

    logic                  slotWrap;
    logic                  bitEnd;
    logic                  sampleNow;
    logic                  refCarrier;
    logic                  phaseSample;
    logic [ONES_W-1:0]     onesWithSample;
    logic                  decided;
    logic [DATA_WIDTH-1:0] wordNext;
    logic                  captureEn;
    logic                  busyState;

    // Slot timing, the phase sample and the majority decision with tie-hold
    always_comb begin
        slotWrap    = (slotCnt_q == SLOT_LAST);
        bitEnd      = slotWrap && (slotIdx_q == IDX_LAST);
        sampleNow   = (slotCnt_q == SLOT_MID);
        refCarrier  = slotIdx_q[0];
        phaseSample = bus.wave_in ^ refCarrier;
        // The current sample is folded in, so a sample on the last clock still counts
        onesWithSample = ones_q + ONES_W'(sampleNow & phaseSample);
        if (onesWithSample > ONES_HALF) begin
            decided = 1'b1;
        end else if (onesWithSample < ONES_HALF) begin
            decided = 1'b0;
        end else begin
            decided = tieBit_q;
        end
    end

    // FSM state register: the preamble bit is always expected first after reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= PREAMBLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the preamble lasts one bit period, then stay in DATA for good
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PREAMBLE: if (bitEnd) state_d = DATA;
            DATA:     state_d = DATA;
            default:  state_d = PREAMBLE;
        endcase
    end

    // FSM outputs: decisions are captured only in DATA; both states count as busy
    always_comb begin
        captureEn = 1'b0;
        busyState = 1'b0;
        unique case (state_q)
            PREAMBLE: begin
                busyState = 1'b1;
            end
            DATA: begin
                busyState = 1'b1;
                captureEn = bitEnd;
            end
            default: begin
                busyState = 1'b0;
            end
        endcase
    end

    // Datapath next state: counters, sample accumulation, frame assembly, output load
    always_comb begin
        slotCnt_d = slotWrap ? '0 : slotCnt_q + 1'b1;
        slotIdx_d = slotIdx_q;
        if (slotWrap) begin
            slotIdx_d = (slotIdx_q == IDX_LAST) ? '0 : slotIdx_q + 1'b1;
        end
        ones_d   = bitEnd ? '0 : onesWithSample;
        tieBit_d = bitEnd ? decided : tieBit_q;

        wordNext           = frame_q;
        wordNext[bitCnt_q] = decided;

        frame_d     = frame_q;
        bitCnt_d    = bitCnt_q;
        dataOut_d   = dataOut_q;
        dataValid_d = 1'b0;
        if (captureEn) begin
            frame_d = wordNext;
            if (bitCnt_q == BIT_LAST) begin
                bitCnt_d    = '0;
                dataOut_d   = wordNext;
                dataValid_d = 1'b1;
            end else begin
                bitCnt_d = bitCnt_q + 1'b1;
            end
        end
    end

    // Datapath registers: everything clears asynchronously, so no partial frame survives
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            slotCnt_q   <= '0;
            slotIdx_q   <= '0;
            ones_q      <= '0;
            tieBit_q    <= 1'b0;
            frame_q     <= '0;
            bitCnt_q    <= '0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
        end else begin
            slotCnt_q   <= slotCnt_d;
            slotIdx_q   <= slotIdx_d;
            ones_q      <= ones_d;
            tieBit_q    <= tieBit_d;
            frame_q     <= frame_d;
            bitCnt_q    <= bitCnt_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
        end
    end

`ifdef BPSK_DEMOD_ERR_EN
    logic errAcc_q, errAcc_d;
    logic symErr_q, symErr_d;
    logic bitErr;

    // A bit is suspect when its samples were not unanimous
    always_comb begin
        bitErr   = (onesWithSample != '0) && (onesWithSample != ONES_W'(S));
        errAcc_d = errAcc_q;
        symErr_d = 1'b0;
        if (captureEn) begin
            if (bitCnt_q == BIT_LAST) begin
                errAcc_d = 1'b0;
                symErr_d = errAcc_q | bitErr;
            end else begin
                errAcc_d = errAcc_q | bitErr;
            end
        end
    end

    // Frame error flag registers, pulsed alongside data_valid
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            errAcc_q <= 1'b0;
            symErr_q <= 1'b0;
        end else begin
            errAcc_q <= errAcc_d;
            symErr_q <= symErr_d;
        end
    end

    assign bus.sym_err = symErr_q;
`endif

    assign bus.data_out   = dataOut_q;
    assign bus.data_valid = dataValid_q;
    // busy is gated by n_rst so that it reads 0 while reset is held
    assign bus.busy       = busyState & n_rst;

endmodule

// File: tb/tb_bpsk_demod.sv
// tb_bpsk_demod: self-checking bench for bpsk_demod.
// A small-parameter instance runs table-driven and random frames. Its
// waveform is generated from a bit/flip schedule, and its expectations come
// from the table or from a slot-counting reference model.
// A default-parameter instance checks absolute latency and mid-frame reset.
module tb_bpsk_demod;

    localparam int DW     = 8;
    localparam int CC     = 4;
    localparam int S      = 2 * CC;
    localparam int SM_CLK = 1_600_000;
    localparam int SM_CAR = 64_000;
    localparam int SM_H   = SM_CLK / (SM_CAR * 2);
    localparam int SM_BIT = SM_H * S;
    localparam int DF_H   = 20_000_000 / (64_000 * 2);
    localparam int DF_BIT = DF_H * S;
    localparam int NT     = 8;
    localparam int NRAND  = 24;

    typedef struct {
        logic [DW-1:0] word;
        int            flipBit;
        logic [S-1:0]  mask;
        logic [DW-1:0] expWord;
        logic          expErr;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst;
    logic n_rst2;
    logic dfDone;

    int checks   = 0;
    int failures = 0;

    logic          txBits[$];
    logic [S-1:0]  flipMasks[$];
    logic [DW-1:0] mWords[$];
    logic          mErrs[$];
    logic [DW-1:0] expWords[$];
    logic          expErrs[$];
    vec_t          vecs[NT];

    always #5 clk = ~clk;

    bpsk_demod_if #(.DATA_WIDTH(DW)) smBus();
    bpsk_demod_if #(.DATA_WIDTH(DW)) dfBus();

    bpsk_demod #(
        .CLOCK_IN(SM_CLK),
        .CLOCK_CARRIER(SM_CAR),
        .DATA_WIDTH(DW),
        .CYCLE_COUNT(CC)
    ) dutSmall (
        .clk(clk),
        .n_rst(n_rst),
        .bus(smBus)
    );

    bpsk_demod dutDefault (
        .clk(clk),
        .n_rst(n_rst2),
        .bus(dfBus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic void clearSchedule();
        txBits.delete();
        flipMasks.delete();
        expWords.delete();
        expErrs.delete();
    endfunction

    function automatic void pushBit(input logic tx, input logic [S-1:0] m);
        txBits.push_back(tx);
        flipMasks.push_back(m);
    endfunction

    function automatic logic [S-1:0] randMask();
        logic [S-1:0] r;
        r = S'($urandom);
        return ($urandom_range(0, 3) == 0) ? r : '0;
    endfunction

    function automatic void pushFrame(input logic [DW-1:0] w, input int fb, input logic [S-1:0] m);
        for (int j = 0; j < DW; j++) pushBit(w[j], (j == fb) ? m : '0);
    endfunction

    function automatic void pushRandomFrame();
        logic [DW-1:0] w;
        w = DW'($urandom);
        for (int j = 0; j < DW; j++) pushBit(w[j], randMask());
    endfunction

    // Reference model: count matching samples per bit, apply majority with tie-hold
    function automatic void runModel();
        logic          tie;
        logic          dec;
        logic [DW-1:0] w;
        logic          e;
        int            ones;
        int            j;
        tie = 1'b0;
        w   = '0;
        e   = 1'b0;
        mWords.delete();
        mErrs.delete();
        for (int g = 0; g < txBits.size(); g++) begin
            ones = 0;
            for (int s = 0; s < S; s++) ones += int'(txBits[g] ^ flipMasks[g][s]);
            dec = (ones > CC) ? 1'b1 : (ones < CC) ? 1'b0 : tie;
            tie = dec;
            if (g > 0) begin
                j    = (g - 1) % DW;
                w[j] = dec;
                if (ones != 0 && ones != S) e = 1'b1;
                if (j == DW - 1) begin
                    mWords.push_back(w);
                    mErrs.push_back(e);
                    w = '0;
                    e = 1'b0;
                end
            end
        end
    endfunction

    // Transmitter waveform for edge e: reference carrier XOR bit XOR any injected flip
    function automatic logic smWave(input int e);
        int   g;
        int   slot;
        logic refc;
        g    = e / SM_BIT;
        slot = (e / SM_H) % S;
        refc = (slot % 2 == 1);
        if (g >= txBits.size()) return refc;
        return refc ^ txBits[g] ^ flipMasks[g][slot];
    endfunction

    function automatic logic dfWave(input int e, input logic [DW-1:0] w);
        int   g;
        int   slot;
        logic tx;
        g    = e / DF_BIT;
        slot = (e / DF_H) % S;
        tx   = (g == 0) ? 1'b0 : w[(g - 1) % DW];
        return (slot % 2 == 1) ^ tx;
    endfunction

    // Drive one waveform sample per edge; check frame ends and hold everything else
    task automatic applyStimulus(input int nEdges, input string tag);
        logic [DW-1:0] lastOut;
        int            stray;
        int            f;
        logic          bad;
        lastOut = '0;
        stray   = 0;
        for (int e = 0; e < nEdges; e++) begin
            smBus.wave_in = smWave(e);
            @(posedge clk);
            #1;
            f = -1;
            if ((e + 1) % SM_BIT == 0 && (e + 1) / SM_BIT > DW && ((e + 1) / SM_BIT - 1) % DW == 0)
                f = ((e + 1) / SM_BIT - 1) / DW - 1;
            if (f >= 0 && f < expWords.size()) begin
                checkOutput($sformatf("%s valid f%0d", tag, f), 32'(smBus.data_valid), 32'd1);
                checkOutput($sformatf("%s data f%0d", tag, f), 32'(smBus.data_out), 32'(expWords[f]));
`ifdef BPSK_DEMOD_ERR_EN
                checkOutput($sformatf("%s symErr f%0d", tag, f), 32'(smBus.sym_err), 32'(expErrs[f]));
`endif
                lastOut = expWords[f];
            end else begin
                bad = (smBus.data_valid !== 1'b0) || (smBus.data_out !== lastOut) || (smBus.busy !== 1'b1);
`ifdef BPSK_DEMOD_ERR_EN
                bad = bad || (smBus.sym_err !== 1'b0);
`endif
                if (bad) stray++;
            end
            @(negedge clk);
        end
        checkOutput({tag, " strayEvents"}, 32'(stray), 32'd0);
    endtask

    // Main sequence on the small instance
    initial begin
        n_rst         = 1'b0;
        smBus.wave_in = 1'b0;
        vecs[0] = '{8'hA5, -1, 8'h00,        8'hA5, 1'b0};
        vecs[1] = '{8'h00,  2, 8'b0000_0111, 8'h00, 1'b1};
        vecs[2] = '{8'h0F,  3, 8'b0000_1111, 8'h0F, 1'b1};
        vecs[3] = '{8'h00, -1, 8'h00,        8'h00, 1'b0};
        vecs[4] = '{8'hFF, -1, 8'h00,        8'hFF, 1'b0};
        vecs[5] = '{8'hFF,  5, 8'b1111_1000, 8'hDF, 1'b1};
        vecs[6] = '{8'h00,  0, 8'b1110_0011, 8'h01, 1'b1};
        vecs[7] = '{8'h3C,  2, 8'b1010_1010, 8'h38, 1'b1};

        #12;
        checkOutput("resetDataOut", 32'(smBus.data_out), 32'd0);
        checkOutput("resetValid", 32'(smBus.data_valid), 32'd0);
        checkOutput("resetBusy", 32'(smBus.busy), 32'd0);

        // Phase A: random frames, then a reset pulse in the middle of the second frame
        clearSchedule();
        pushBit(logic'($urandom_range(0, 1)), randMask());
        for (int i = 0; i < 3; i++) pushRandomFrame();
        runModel();
        expWords = mWords;
        expErrs  = mErrs;
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        checkOutput("busyCycle0", 32'(smBus.busy), 32'd1);
        applyStimulus(SM_BIT * (1 + DW) + SM_BIT * 3 + 40, "phaseA");
        #1;
        n_rst = 1'b0;
        #1;
        checkOutput("midResetDataOut", 32'(smBus.data_out), 32'd0);
        checkOutput("midResetValid", 32'(smBus.data_valid), 32'd0);
        checkOutput("midResetBusy", 32'(smBus.busy), 32'd0);
`ifdef BPSK_DEMOD_ERR_EN
        checkOutput("midResetSymErr", 32'(smBus.sym_err), 32'd0);
`endif
        repeat (2) @(posedge clk);

        // Phase B: table frames followed by random frames, fresh preamble after reset
        clearSchedule();
        pushBit(1'b0, '0);
        for (int i = 0; i < NT; i++) pushFrame(vecs[i].word, vecs[i].flipBit, vecs[i].mask);
        for (int i = 0; i < NRAND; i++) pushRandomFrame();
        runModel();
        for (int i = 0; i < NT; i++) begin
            expWords.push_back(vecs[i].expWord);
            expErrs.push_back(vecs[i].expErr);
        end
        for (int i = NT; i < NT + NRAND; i++) begin
            expWords.push_back(mWords[i]);
            expErrs.push_back(mErrs[i]);
        end
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        checkOutput("busyAfterRestart", 32'(smBus.busy), 32'd1);
        applyStimulus(SM_BIT * (1 + DW * (NT + NRAND)) + 20, "phaseB");

        for (int i = 0; i < 60000 && !dfDone; i++) @(posedge clk);
        checkOutput("defaultInstanceDone", 32'(dfDone), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Default-parameter instance: reset at cycle 5000, then A5 loopback latency
    initial begin
        logic [DW-1:0] dfWord;
        logic [DW-1:0] lastOut;
        int            stray;
        logic          bad;
        dfDone        = 1'b0;
        dfWord        = 8'hA5;
        n_rst2        = 1'b0;
        dfBus.wave_in = 1'b0;
        stray         = 0;
        #12;
        @(negedge clk);
        n_rst2 = 1'b1;
        for (int e = 0; e < 5000; e++) begin
            dfBus.wave_in = dfWave(e, dfWord);
            @(posedge clk);
            #1;
            if (dfBus.data_valid !== 1'b0 || dfBus.data_out !== '0) stray++;
            @(negedge clk);
        end
        n_rst2 = 1'b0;
        #1;
        checkOutput("dfPreResetStray", 32'(stray), 32'd0);
        checkOutput("dfResetDataOut", 32'(dfBus.data_out), 32'd0);
        checkOutput("dfResetValid", 32'(dfBus.data_valid), 32'd0);
        checkOutput("dfResetBusy", 32'(dfBus.busy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst2 = 1'b1;
        #1;
        checkOutput("dfBusyCycle0", 32'(dfBus.busy), 32'd1);
        stray   = 0;
        lastOut = '0;
        for (int e = 0; e < DF_BIT * (1 + 2 * DW) + 10; e++) begin
            dfBus.wave_in = dfWave(e, dfWord);
            @(posedge clk);
            #1;
            if ((e + 1) % DF_BIT == 0 && (e + 1) / DF_BIT > DW && ((e + 1) / DF_BIT - 1) % DW == 0) begin
                checkOutput($sformatf("dfValid cycle%0d", e + 1), 32'(dfBus.data_valid), 32'd1);
                checkOutput($sformatf("dfData cycle%0d", e + 1), 32'(dfBus.data_out), 32'(dfWord));
`ifdef BPSK_DEMOD_ERR_EN
                checkOutput($sformatf("dfSymErr cycle%0d", e + 1), 32'(dfBus.sym_err), 32'd0);
`endif
                lastOut = dfWord;
            end else begin
                bad = (dfBus.data_valid !== 1'b0) || (dfBus.data_out !== lastOut);
`ifdef BPSK_DEMOD_ERR_EN
                bad = bad || (dfBus.sym_err !== 1'b0);
`endif
                if (bad) stray++;
            end
            @(negedge clk);
        end
        checkOutput("dfStrayEvents", 32'(stray), 32'd0);
        dfDone = 1'b1;
    end

endmodule
